// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR datapath.
// Default widths, pipeline depth and the frame-marker record used by fir_mac.
package fir_pkg;

    localparam int FIR_A_W     = 16;
    localparam int FIR_B_W     = 16;
    localparam int FIR_ACC_W   = 40;
    localparam int FIR_OUT_W   = 32;
    localparam int FIR_MAC_LAT = 3;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } fir_mark_t;

endpackage

// File: rtl/fir_mac_scale.sv
// Arithmetic right shift of the accumulator and reduction to the output width.
// FIR_MAC_SAT_EN selects clamping with an overflow flag; otherwise plain truncation.
module fir_mac_scale #(
    parameter int ACC_W = 40,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] res,
    output logic                    ovf
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> SHIFT;

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        res = shifted[OUT_W-1:0];
        ovf = 1'b0;
        if (shifted > MAX_V) begin
            res = MAX_V[OUT_W-1:0];
            ovf = 1'b1;
        end else if (shifted < MIN_V) begin
            res = MIN_V[OUT_W-1:0];
            ovf = 1'b1;
        end
    end
`else
    // Bits above OUT_W are intentionally dropped in the wrapping build.
    logic unused_bits;
    assign unused_bits = ^shifted;
    assign res = shifted[OUT_W-1:0];
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/fir_mac.sv
// Pipelined signed multiply-accumulate: S1 operands, S2 product, S3 accumulator/output.
// Define FIR_MAC_SAT_EN to saturate the scaled result and drive dout_ovf.
module fir_mac
    import fir_pkg::*;
#(
    parameter int A_W   = FIR_A_W,
    parameter int B_W   = FIR_B_W,
    parameter int ACC_W = FIR_ACC_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    dout_ovf
);

    localparam int P_W = A_W + B_W;

    if (ACC_W < P_W) begin : g_bad_acc_w
        $error("fir_mac: ACC_W must be >= A_W+B_W");
    end
    if (OUT_W > ACC_W) begin : g_bad_out_w
        $error("fir_mac: OUT_W must be <= ACC_W");
    end
    if (SHIFT > ACC_W - OUT_W) begin : g_bad_shift
        $error("fir_mac: SHIFT must be <= ACC_W-OUT_W");
    end

    fir_mark_t               mark1, mark2;
    logic signed [A_W-1:0]   a1;
    logic signed [B_W-1:0]   b1;
    logic signed [P_W-1:0]   prod2;
    logic signed [ACC_W-1:0] acc, acc_next, prod_ext;
    logic signed [OUT_W-1:0] scaled;
    logic                    scaled_ovf;
    logic                    emit;

    assign prod_ext = ACC_W'(prod2);
    assign acc_next = mark2.first ? prod_ext : acc + prod_ext;
    assign emit     = mark2.valid && mark2.last;

    fir_mac_scale #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT)
    ) u_scale (
        .acc(acc_next),
        .res(scaled),
        .ovf(scaled_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mark1      <= '0;
            mark2      <= '0;
            a1         <= '0;
            b1         <= '0;
            prod2      <= '0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (ce) begin
            mark1      <= '{valid: in_valid, first: in_first, last: in_last};
            a1         <= a;
            b1         <= b;
            mark2      <= mark1;
            prod2      <= P_W'(a1) * P_W'(b1);
            dout_valid <= emit;
            // Bubbles leave the partial sum untouched, whatever their markers say.
            if (mark2.valid) begin
                acc <= acc_next;
            end
            if (emit) begin
                dout <= scaled;
            end
        end
    end

`ifdef FIR_MAC_SAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_ovf <= 1'b0;
        end else if (ce && emit) begin
            dout_ovf <= scaled_ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = scaled_ovf;
    assign dout_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mac.sv
// Directed bench for fir_mac: vector table for the main frames plus hand sequences
// for the narrow-output scaling case and a mid-frame reset.
module tb_fir_mac;
    import fir_pkg::*;

    typedef struct {
        bit ce;
        bit v;
        bit f;
        bit l;
        int a;
        int b;
        bit ev;
        int ed;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic ce;
    logic in_valid, in_first, in_last;
    logic signed [15:0] a, b;
    logic signed [31:0] dout;
    logic dout_valid, dout_ovf;
    logic signed [15:0] dout2;
    logic dout_valid2, dout_ovf2;

    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fir_mac dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a), .b(b),
        .dout(dout), .dout_valid(dout_valid), .dout_ovf(dout_ovf)
    );

    fir_mac #(.A_W(16), .B_W(16), .ACC_W(40), .OUT_W(16), .SHIFT(8)) dut_narrow (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a), .b(b),
        .dout(dout2), .dout_valid(dout_valid2), .dout_ovf(dout_ovf2)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic row(input bit ce_i, input bit v, input bit f, input bit l,
                       input int av, input int bv, input bit ev, input int ed);
        vec_t r;
        r.ce = ce_i; r.v = v; r.f = f; r.l = l;
        r.a = av; r.b = bv; r.ev = ev; r.ed = ed;
        tbl.push_back(r);
    endtask

    task automatic drive(input bit ce_i, input bit v, input bit f, input bit l, input int av, input int bv);
        ce       = ce_i;
        in_valid = v;
        in_first = f;
        in_last  = l;
        a        = 16'(av);
        b        = 16'(bv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ce  v  f  l   a       b      exp_valid exp_dout
        row(1, 1, 1, 0, 1, 10, 0, 0);
        row(1, 1, 0, 0, 2, 10, 0, 0);
        row(1, 1, 0, 0, 3, 10, 0, 0);
        row(1, 1, 0, 1, 4, 10, 0, 0);
        row(1, 0, 0, 0, 0, 0, 0, 0);
        row(1, 0, 0, 0, 0, 0, 1, 100);
        row(1, 0, 0, 0, 0, 0, 0, 100);
        row(1, 1, 1, 1, -32768, -32768, 0, 100);
        row(1, 0, 0, 0, 0, 0, 0, 100);
        row(1, 0, 0, 0, 0, 0, 1, 1073741824);
        row(1, 0, 0, 0, 0, 0, 0, 1073741824);
        // back-to-back frames
        row(1, 1, 1, 0, 1, 1, 0, 1073741824);
        row(1, 1, 0, 1, 2, 2, 0, 1073741824);
        row(1, 1, 1, 1, 3, 3, 0, 1073741824);
        row(1, 0, 0, 0, 0, 0, 1, 5);
        row(1, 0, 0, 0, 0, 0, 1, 9);
        row(1, 0, 0, 0, 0, 0, 0, 9);
        // bubble carrying markers, then clock-enable stall with junk on the inputs
        row(1, 1, 1, 0, 5, 5, 0, 9);
        row(1, 0, 1, 1, 77, 77, 0, 9);
        for (int i = 0; i < 4; i++) row(0, 1, 1, 1, 99, 99, 0, 9);
        row(1, 1, 0, 1, 5, 5, 0, 9);
        row(1, 0, 0, 0, 0, 0, 0, 9);
        row(1, 0, 0, 0, 0, 0, 1, 50);
        row(1, 0, 0, 0, 0, 0, 0, 50);
        // valid strobe frozen by ce=0
        row(1, 1, 1, 1, 2, 3, 0, 50);
        row(1, 0, 0, 0, 0, 0, 0, 50);
        row(1, 0, 0, 0, 0, 0, 1, 6);
        row(0, 0, 0, 0, 0, 0, 1, 6);
        row(0, 0, 0, 0, 0, 0, 1, 6);
        row(1, 0, 0, 0, 0, 0, 0, 6);

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("reset dout", dout, 0);
        chk("reset dout_valid", dout_valid, 0);
        chk("reset dout_ovf", dout_ovf, 0);
        chk("reset narrow ovf", dout_ovf2, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].ce, tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].a, tbl[i].b);
            step();
            chk($sformatf("row%0d dout_valid", i), dout_valid, tbl[i].ev);
            chk($sformatf("row%0d dout", i), dout, tbl[i].ed);
            chk($sformatf("row%0d dout_ovf", i), dout_ovf, 0);
        end

        // Four full-scale products: 4294705156 overflows both output widths.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i == 0, i == 3, 32767, 32767);
            step();
        end
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("sat pre dout_valid", dout_valid2, 0);
        step();
        chk("sat narrow dout_valid", dout_valid2, 1);
        chk("sat wide dout_valid", dout_valid, 1);
`ifdef FIR_MAC_SAT_EN
        chk("sat narrow dout", dout2, 32767);
        chk("sat narrow ovf", dout_ovf2, 1);
        chk("sat wide dout", dout, 2147483647);
        chk("sat wide ovf", dout_ovf, 1);
`else
        chk("sat narrow dout", dout2, -1024);
        chk("sat narrow ovf", dout_ovf2, 0);
        chk("sat wide dout", dout, -262140);
        chk("sat wide ovf", dout_ovf, 0);
`endif
        step();
        chk("sat post dout_valid", dout_valid2, 0);

        // Reset while a last beat is still inside the pipeline.
        drive(1, 1, 1, 0, 1, 1);
        step();
        drive(1, 1, 0, 1, 2, 2);
        step();
        drive(1, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset dout", dout, 0);
        chk("midreset dout_valid", dout_valid, 0);
        chk("midreset dout_ovf", dout_ovf, 0);
        chk("midreset narrow dout", dout2, 0);
        chk("midreset narrow ovf", dout_ovf2, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("held reset dout_valid", dout_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("aborted frame dout_valid%0d", i), dout_valid, 0);
            chk($sformatf("aborted frame dout%0d", i), dout, 0);
        end
        drive(1, 1, 1, 1, 7, 3);
        step();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 1; i < FIR_MAC_LAT; i++) begin
            chk($sformatf("post reset wait%0d", i), dout_valid, 0);
            step();
        end
        chk("post reset dout_valid", dout_valid, 1);
        chk("post reset dout", dout, 21);
        step();
        chk("post reset strobe end", dout_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
